pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage RV64 pipeline. It sits beside the ID stage and supplies the MEM/WB destination-tracking signals that the forwarding unit consumes.
- Decodes the ID instruction's register usage and tracks in-flight writers through EX/MEM/WB in its own shadow registers.
- Generates PC/IF-ID hold, ID flush and EX bubble for load-use hazards, EX redirects and data-memory wait states. Keeps saturating hazard counters for performance debug.

---
 rtl/pipeline_hazard_ctrl.sv | 120 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller beside ID: decodes register usage, shadows EX/MEM/WB writers,
// and raises hold, flush and bubble controls for memory waits, redirects and load-use hazards.
module pipeline_hazard_ctrl #(
    parameter int unsigned LOAD_USE_STALL = 1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [31:0]      id_inst,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_stall,
    output logic [4:0]       MEMrd,
    output logic [4:0]       WBrd,
    output logic             MEMwe_reg,
    output logic             WBwe_reg,
    output logic             MEMre_mem,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       load;
        logic       store;
    } shadow_t;

    shadow_t    id_dec, ex_q, mem_q, wb_q;
    logic       uses_rs1, uses_rs2;
    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic       mem_wait, load_use;

    assign opcode = id_inst[6:0];
    assign rd     = id_inst[11:7];
    assign rs1    = id_inst[19:15];
    assign rs2    = id_inst[24:20];

    always_comb begin
        id_dec   = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        if (id_valid) begin
            id_dec.valid = 1'b1;
            id_dec.load  = (opcode == OP_LOAD);
            id_dec.store = (opcode == OP_STORE);
            case (opcode)
                OP_OP, OP_OP32, OP_IMM, OP_IMM32, OP_LOAD,
                OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: id_dec.we = (rd != 5'd0);
                default:                           id_dec.we = 1'b0;
            endcase
            if (id_dec.we)
                id_dec.rd = rd;
            uses_rs1 = !(opcode == OP_JAL || opcode == OP_LUI || opcode == OP_AUIPC);
            uses_rs2 = (opcode == OP_OP) || (opcode == OP_OP32) ||
                       (opcode == OP_BRANCH) || (opcode == OP_STORE);
        end
    end

    assign mem_wait = mem_busy && mem_q.valid && (mem_q.load || mem_q.store);
    assign load_use = (LOAD_USE_STALL != 0) && ex_q.valid && ex_q.load && (ex_q.rd != 5'd0) &&
                      ((uses_rs1 && rs1 == ex_q.rd) || (uses_rs2 && rs2 == ex_q.rd));

    // Memory wait outranks a redirect; a redirect outranks load-use, so no stall is raised then.
    assign exmem_stall = mem_wait;
    assign ifid_flush  = !mem_wait && ex_redirect;
    assign idex_bubble = !mem_wait && (ex_redirect || load_use);
    assign pc_stall    = mem_wait || (!ex_redirect && load_use);
    assign ifid_stall  = pc_stall;

    assign MEMrd     = mem_q.rd;
    assign WBrd      = wb_q.rd;
    assign MEMwe_reg = mem_q.valid && mem_q.we;
    assign WBwe_reg  = wb_q.valid && wb_q.we;
    assign MEMre_mem = mem_q.valid && mem_q.load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!mem_wait) begin
            ex_q  <= (ex_redirect || load_use) ? '0 : id_dec;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (ifid_flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: per-step expectations go through a scoreboard queue
// and are checked mid-cycle with immediate assertions.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic [31:0]   id_inst;
    logic          ex_redirect;
    logic          mem_busy;
    logic          pc_stall, ifid_stall, ifid_flush, idex_bubble, exmem_stall;
    logic [4:0]    MEMrd, WBrd;
    logic          MEMwe_reg, WBwe_reg, MEMre_mem;
    logic [CW-1:0] stall_cnt, flush_cnt;

    logic          n_pc_stall, n_ifid_stall, n_ifid_flush, n_idex_bubble, n_exmem_stall;
    logic [4:0]    n_MEMrd, n_WBrd;
    logic          n_MEMwe_reg, n_WBwe_reg, n_MEMre_mem;
    logic [CW-1:0] n_stall_cnt, n_flush_cnt;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic        chk_nolus = 1'b0;

    typedef struct packed {
        logic [4:0]    ctl;
        logic [4:0]    memrd;
        logic [4:0]    wbrd;
        logic [2:0]    fl;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.LOAD_USE_STALL(1), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_inst(id_inst),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .exmem_stall(exmem_stall),
        .MEMrd(MEMrd), .WBrd(WBrd), .MEMwe_reg(MEMwe_reg), .WBwe_reg(WBwe_reg),
        .MEMre_mem(MEMre_mem), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.LOAD_USE_STALL(0), .CNT_W(CW)) dut_nolus (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_inst(id_inst),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .pc_stall(n_pc_stall), .ifid_stall(n_ifid_stall), .ifid_flush(n_ifid_flush),
        .idex_bubble(n_idex_bubble), .exmem_stall(n_exmem_stall),
        .MEMrd(n_MEMrd), .WBrd(n_WBrd), .MEMwe_reg(n_MEMwe_reg), .WBwe_reg(n_WBwe_reg),
        .MEMre_mem(n_MEMre_mem), .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
    );

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, op};
    endfunction

    // ctl = {pc_stall, ifid_stall, ifid_flush, idex_bubble, exmem_stall}
    // fl  = {MEMwe_reg, WBwe_reg, MEMre_mem}
    task automatic step(input logic v, input logic [31:0] inst, input logic redir,
                        input logic busy, input string tag, input logic [4:0] ctl,
                        input logic [4:0] memrd, input logic [4:0] wbrd, input logic [2:0] fl,
                        input logic [CW-1:0] sc, input logic [CW-1:0] fc);
        exp_t e, got;
        string t;
        id_valid    = v;
        id_inst     = inst;
        ex_redirect = redir;
        mem_busy    = busy;
        e = '{ctl: ctl, memrd: memrd, wbrd: wbrd, fl: fl, sc: sc, fc: fc};
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #4;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        got = '{ctl: {pc_stall, ifid_stall, ifid_flush, idex_bubble, exmem_stall},
                memrd: MEMrd, wbrd: WBrd, fl: {MEMwe_reg, WBwe_reg, MEMre_mem},
                sc: stall_cnt, fc: flush_cnt};
        checks++;
        assert (got === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (ctl memrd wbrd fl sc fc)", t, got, e);
        end
        if (chk_nolus) begin
            checks++;
            assert (n_pc_stall === 1'b0) else begin
                errors++;
                $error("FAIL %s_nolus observed pc_stall=%b expected=0", t, n_pc_stall);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] add5, ld7, add8, lui7, jal7;
        add5 = enc(7'b0110011, 5'd5, 5'd1, 5'd2);
        ld7  = enc(7'b0000011, 5'd7, 5'd2, 5'd0);
        add8 = enc(7'b0110011, 5'd8, 5'd7, 5'd3);
        lui7 = enc(7'b0110111, 5'd7, 5'd7, 5'd7);
        jal7 = enc(7'b1101111, 5'd7, 5'd7, 5'd7);

        rst_n = 1'b0; id_valid = 1'b0; id_inst = '0; ex_redirect = 1'b0; mem_busy = 1'b1;
        @(posedge clk);
        #1;
        step(1, add5, 0, 1, "reset_hold", 5'b00000, 0, 0, 3'b000, 0, 0);
        rst_n = 1'b1;
        step(0, '0,   0, 0, "post_reset",  5'b00000, 0, 0, 3'b000, 0, 0);

        step(1, add5, 0, 0, "add_in_id",   5'b00000, 0, 0, 3'b000, 0, 0);
        step(0, '0,   0, 0, "add_in_ex",   5'b00000, 0, 0, 3'b000, 0, 0);
        step(0, '0,   0, 0, "add_in_mem",  5'b00000, 5, 0, 3'b100, 0, 0);
        step(0, '0,   0, 0, "add_in_wb",   5'b00000, 0, 5, 3'b010, 0, 0);

        step(1, ld7,  0, 0, "ld_in_id",    5'b00000, 0, 0, 3'b000, 0, 0);
        chk_nolus = 1'b1;
        step(1, add8, 0, 0, "load_use",    5'b11010, 0, 0, 3'b000, 0, 0);
        chk_nolus = 1'b0;
        step(1, add8, 0, 0, "ld_in_mem",   5'b00000, 7, 0, 3'b101, 1, 0);

        step(1, ld7,  0, 0, "ld_again",    5'b00000, 0, 7, 3'b010, 1, 0);
        step(1, lui7, 0, 0, "lui_no_use",  5'b00000, 8, 0, 3'b100, 1, 0);
        step(1, ld7,  0, 0, "ld_third",    5'b00000, 7, 8, 3'b111, 1, 0);
        step(1, jal7, 0, 0, "jal_no_use",  5'b00000, 7, 7, 3'b110, 1, 0);

        step(1, ld7,  0, 0, "ld_fourth",   5'b00000, 7, 7, 3'b111, 1, 0);
        step(1, add8, 1, 0, "redir_wins",  5'b00110, 7, 7, 3'b110, 1, 0);

        step(0, '0,   1, 1, "memwait_1",   5'b11001, 7, 7, 3'b111, 1, 1);
        step(0, '0,   1, 1, "memwait_2",   5'b11001, 7, 7, 3'b111, 2, 1);
        step(0, '0,   1, 1, "memwait_3",   5'b11001, 7, 7, 3'b111, 3, 1);
        step(0, '0,   1, 0, "wait_done",   5'b00110, 7, 7, 3'b111, 4, 1);
        step(0, '0,   0, 0, "flush_cnt",   5'b00000, 0, 7, 3'b010, 4, 2);

        step(1, ld7,  0, 0, "sat_ld_id",   5'b00000, 0, 0, 3'b000, 4, 2);
        step(0, '0,   0, 0, "sat_ld_ex",   5'b00000, 0, 0, 3'b000, 4, 2);
        for (int k = 0; k < 13; k++) begin
            int unsigned s;
            s = (4 + k > 15) ? 15 : 4 + k;
            step(0, '0, 0, 1, $sformatf("sat_%0d", k), 5'b11001, 7, 0, 3'b101, CW'(s), 2);
        end

        rst_n = 1'b0;
        step(0, '0,   0, 1, "reset_mid",   5'b00000, 0, 0, 3'b000, 0, 0);
        rst_n = 1'b1;
        step(0, '0,   0, 1, "after_rst",   5'b00000, 0, 0, 3'b000, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
